pending_scheduler: RTL and testbench

- Sequential scheduler over a WIDTH-bit pending-request bitmap (event, IRQ or work-queue flags).
- Each cycle it selects one pending index using highest-set-bit encoding, in fixed-priority or descending round-robin mode.
- The selected index goes to a registered valid/ready output stage, and that pending bit is retired.
- Sits between request sources and a single consumer that services one index at a time.

---
 rtl/pending_scheduler_pkg.sv | 18 +
 rtl/pending_scheduler_msb_index.sv | 22 ++
 rtl/pending_scheduler.sv | 85 ++++++++
 tb/tb_pending_scheduler.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/pending_scheduler_pkg.sv
// Shared definitions for the pending-request scheduler: index-width derivation
// and the selection-mode encoding.
package pending_scheduler_pkg;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  // Ceiling log2, usable in parameter expressions; floored at 1 bit.
  function automatic int idx_width(input int w);
    int r;
    r = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < w) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/pending_scheduler_msb_index.sv
// Combinational highest-set-bit encoder with an any-bit-set flag.
import pending_scheduler_pkg::*;

module pending_scheduler_msb_index #(
  parameter int WIDTH     = 32,
  parameter int IDX_WIDTH = idx_width(WIDTH)
) (
  input  logic [WIDTH-1:0]     vec,
  output logic [IDX_WIDTH-1:0] idx,
  output logic                 any_set
);

  // Ascending scan so the last (highest) set bit overwrites earlier hits.
  always_comb begin
    idx     = '0;
    any_set = |vec;
    for (int i = 0; i < WIDTH; i++) begin
      if (vec[i]) idx = IDX_WIDTH'(i);
    end
  end

endmodule

// File: rtl/pending_scheduler.sv
// Pending-bitmap scheduler: picks one pending index per cycle (fixed priority or
// descending round-robin), presents it on a registered valid/ready stage and retires it.
import pending_scheduler_pkg::*;

module pending_scheduler #(
  parameter  int WIDTH     = 32,
  localparam int IDX_WIDTH = idx_width(WIDTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WIDTH-1:0]     req_set,
  input  logic                 flush,
  input  logic                 mode,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [IDX_WIDTH-1:0] out_idx,
  output logic [WIDTH-1:0]     pending
);

  logic [IDX_WIDTH-1:0] rr_ptr;
  logic [WIDTH-1:0]     mask;
  logic [WIDTH-1:0]     masked;
  logic [IDX_WIDTH-1:0] full_idx;
  logic [IDX_WIDTH-1:0] masked_idx;
  logic                 full_any;
  logic                 masked_any;
  logic [IDX_WIDTH-1:0] sel;
  logic                 load;
  logic [WIDTH-1:0]     retire;

  // Round-robin window: indices strictly below the last grant.
  assign mask   = (WIDTH'(1) << rr_ptr) - WIDTH'(1);
  assign masked = pending & mask;

  pending_scheduler_msb_index #(
    .WIDTH     (WIDTH),
    .IDX_WIDTH (IDX_WIDTH)
  ) u_full_enc (
    .vec     (pending),
    .idx     (full_idx),
    .any_set (full_any)
  );

  pending_scheduler_msb_index #(
    .WIDTH     (WIDTH),
    .IDX_WIDTH (IDX_WIDTH)
  ) u_masked_enc (
    .vec     (masked),
    .idx     (masked_idx),
    .any_set (masked_any)
  );

  // Empty window wraps round-robin back to the overall highest pending bit.
  always_comb begin
    sel = full_idx;
    if (mode == MODE_RR && masked_any) sel = masked_idx;
  end

  assign load   = (!out_valid || out_ready) && full_any;
  assign retire = load ? (WIDTH'(1) << sel) : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending   <= '0;
      out_valid <= 1'b0;
      out_idx   <= '0;
      rr_ptr    <= '0;
    end else if (flush) begin
      pending   <= '0;
      out_valid <= 1'b0;
      rr_ptr    <= '0;
    end else begin
      // A set in the retire cycle re-arms the bit.
      pending <= (pending & ~retire) | req_set;
      if (load) begin
        out_idx   <= sel;
        out_valid <= 1'b1;
        rr_ptr    <= sel;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pending_scheduler.sv
// Directed self-checking bench for pending_scheduler at WIDTH = 8.
module tb_pending_scheduler;

  localparam int WIDTH = 8;

  logic       clk;
  logic       rst;
  logic [7:0] req_set;
  logic       flush;
  logic       mode;
  logic       out_valid;
  logic       out_ready;
  logic [2:0] out_idx;
  logic [7:0] pending;

  int checks;
  int errors;

  pending_scheduler #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_set   (req_set),
    .flush     (flush),
    .mode      (mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_idx   (out_idx),
    .pending   (pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle of inputs, then settle just past the capturing edge.
  task automatic applyStimulus(input logic [7:0] r, input logic f, input logic m,
                               input logic rdy);
    req_set   = r;
    flush     = f;
    mode      = m;
    out_ready = rdy;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
    end
  endtask

  initial begin
    logic [2:0] rr_exp [4];
    rr_exp[0] = 3'd7; rr_exp[1] = 3'd0; rr_exp[2] = 3'd7; rr_exp[3] = 3'd0;
    checks    = 0;
    errors    = 0;
    rst       = 1'b1;
    req_set   = '0;
    flush     = 1'b0;
    mode      = 1'b0;
    out_ready = 1'b0;
    #3;
    checkOutput("por_pending", pending, 8'h00);
    checkOutput("por_valid", out_valid, 1'b0);
    checkOutput("por_idx", out_idx, 3'd0);
    @(negedge clk);
    rst = 1'b0;

    // Async reset in the middle of a held grant.
    applyStimulus(8'h36, 0, 0, 0);
    applyStimulus(8'h36, 0, 0, 0);
    checkOutput("pre_rst_pending", pending, 8'h36);
    checkOutput("pre_rst_valid", out_valid, 1'b1);
    checkOutput("pre_rst_idx", out_idx, 3'd5);
    req_set = '0;
    #2 rst = 1'b1;
    #1;
    checkOutput("async_rst_pending", pending, 8'h00);
    checkOutput("async_rst_valid", out_valid, 1'b0);
    checkOutput("async_rst_idx", out_idx, 3'd0);
    #1 rst = 1'b0;

    // Fixed-priority drain.
    applyStimulus(8'h26, 0, 0, 1);
    checkOutput("drain_load_valid", out_valid, 1'b0);
    applyStimulus(8'h00, 0, 0, 1);
    checkOutput("drain_idx0", out_idx, 3'd5);
    checkOutput("drain_valid0", out_valid, 1'b1);
    checkOutput("drain_pend0", pending, 8'h06);
    applyStimulus(8'h00, 0, 0, 1);
    checkOutput("drain_idx1", out_idx, 3'd2);
    checkOutput("drain_pend1", pending, 8'h02);
    applyStimulus(8'h00, 0, 0, 1);
    checkOutput("drain_idx2", out_idx, 3'd1);
    checkOutput("drain_pend2", pending, 8'h00);
    applyStimulus(8'h00, 0, 0, 1);
    checkOutput("drain_end_valid", out_valid, 1'b0);
    checkOutput("drain_end_idx", out_idx, 3'd1);

    // Backpressure holds the output and retires nothing.
    applyStimulus(8'h26, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(8'h00, 0, 0, 0);
      checkOutput("bp_idx", out_idx, 3'd5);
      checkOutput("bp_valid", out_valid, 1'b1);
      checkOutput("bp_pending", pending, 8'h06);
    end
    applyStimulus(8'h00, 0, 0, 1);
    checkOutput("bp_rel_idx0", out_idx, 3'd2);
    applyStimulus(8'h00, 0, 0, 1);
    checkOutput("bp_rel_idx1", out_idx, 3'd1);
    checkOutput("bp_rel_valid1", out_valid, 1'b1);
    applyStimulus(8'h00, 0, 0, 1);
    checkOutput("bp_rel_end", out_valid, 1'b0);

    // Fairness, fixed priority: index 7 always wins.
    applyStimulus(8'h81, 0, 0, 1);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(8'h81, 0, 0, 1);
      checkOutput("fix_idx", out_idx, 3'd7);
      checkOutput("fix_valid", out_valid, 1'b1);
    end

    // Fairness, round-robin from a cleared pointer.
    applyStimulus(8'h00, 1, 1, 1);
    checkOutput("rr_flush_pending", pending, 8'h00);
    checkOutput("rr_flush_valid", out_valid, 1'b0);
    applyStimulus(8'h81, 0, 1, 1);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(8'h81, 0, 1, 1);
      checkOutput("rr_idx", out_idx, rr_exp[i]);
      checkOutput("rr_pending", pending, 8'h81);
    end
    applyStimulus(8'h00, 1, 0, 1);

    // Set wins over retire of the same bit.
    applyStimulus(8'h08, 0, 0, 1);
    applyStimulus(8'h08, 0, 0, 1);
    checkOutput("setwin_idx", out_idx, 3'd3);
    checkOutput("setwin_pending", pending, 8'h08);
    applyStimulus(8'h00, 0, 0, 1);
    checkOutput("setwin_regrant_idx", out_idx, 3'd3);
    checkOutput("setwin_regrant_valid", out_valid, 1'b1);
    checkOutput("setwin_regrant_pend", pending, 8'h00);
    applyStimulus(8'h00, 0, 0, 1);
    checkOutput("setwin_end", out_valid, 1'b0);

    // Flush discards same-cycle sets and resets the round-robin pointer.
    applyStimulus(8'hF0, 0, 0, 0);
    applyStimulus(8'hF0, 0, 0, 0);
    checkOutput("fl_pre_pending", pending, 8'hF0);
    checkOutput("fl_pre_valid", out_valid, 1'b1);
    applyStimulus(8'h01, 1, 0, 0);
    checkOutput("fl_pending", pending, 8'h00);
    checkOutput("fl_valid", out_valid, 1'b0);
    applyStimulus(8'h11, 0, 1, 1);
    checkOutput("fl_new_pending", pending, 8'h11);
    applyStimulus(8'h00, 0, 1, 1);
    checkOutput("fl_rr_idx0", out_idx, 3'd4);
    checkOutput("fl_rr_pend0", pending, 8'h01);
    applyStimulus(8'h00, 0, 1, 1);
    checkOutput("fl_rr_idx1", out_idx, 3'd0);
    applyStimulus(8'h00, 0, 1, 1);
    checkOutput("fl_rr_end", out_valid, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
